weight_az_param: RTL
====================

WEIGHT_AZ_PARAM -- requirements
Module: weight_az_param

Interface
REQ-001 SHALL have parameter ORDER, default 10, meaning LPC order M (coefficients 0..M per set); legal range 2..16.
REQ-002 SHALL have parameter AW, default 12, meaning memory address width.
REQ-003 SHALL have parameter DW, default 32, meaning memory word width; coefficients occupy bits [15:0].
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 SHALL have port dual  in  1  mode select, sampled with start: 0 = one set, 1 = two sets.
REQ-008 SHALL have port A  in  AW  base address of a[0..M].
REQ-009 SHALL have port AP  in  AW  base address of first output set.
REQ-010 SHALL have port AP2  in  AW  base address of second output set (dual only).
REQ-011 SHALL have port gammaAddr  in  AW  address of gamma1; gamma2 at gammaAddr+1.
REQ-012 SHALL have port readIn  in  DW  read data, valid the cycle after readAddr is presented.
REQ-013 SHALL have port readAddr  out  AW  registered read address.
REQ-014 SHALL have port writeAddr  out  AW  registered write address.
REQ-015 SHALL have port writeOut  out  DW  registered write data, 16-bit result sign-extended.
REQ-016 SHALL have port writeEn  out  1  registered write strobe.
REQ-017 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-018 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-019 SHALL compute ap[0]=a[0]; fac=gamma; for i=1..M: ap[i]=round(L_mult(a[i],fac)), then fac=round(L_mult(gamma,fac)).
REQ-020 SHALL implement L_mult(x,y) as (x*y)<<1 on signed 16-bit operands, with 0x8000*0x8000 saturating to 0x7FFFFFFF.
REQ-021 SHALL implement round(L) as saturating 32-bit add of 0x00008000, returning bits [31:16].
REQ-022 SHALL implement the FSM states IDLE, RG, LG, RA, WA, DONE.
REQ-023 FSM transitions: IDLE->RG on start; RG->LG; LG->RA; RA->WA; WA->RA while i<M; WA->RG at i=M when dual and the first pass is complete; otherwise WA->DONE; DONE->IDLE.
REQ-024 RG SHALL present gammaAddr (pass 1) or gammaAddr+1 (pass 2) on readAddr.
REQ-025 LG SHALL latch gamma=readIn[15:0], set fac=gamma and i=0.
REQ-026 RA SHALL present A+i on readAddr.
REQ-027 WA SHALL drive writeAddr=base+i, writeEn=1 and the result on writeOut; i SHALL increment.
REQ-028 writeOut SHALL be a[0] unmodified at i=0 and the REQ-019 value otherwise; base SHALL be AP on pass 1 and AP2 on pass 2.
REQ-029 writeEn SHALL be high only in WA, exactly M+1 cycles per pass.
REQ-030 Latency: with start accepted in cycle T, done SHALL be high at T+2M+5 (single) or T+4M+9 (dual); M=10 gives T+25 and T+49.
REQ-031 start while busy SHALL be ignored and SHALL NOT alter mode, bases or progress.
REQ-032 A, AP, AP2, gammaAddr and dual SHALL be latched at start acceptance; later input changes SHALL have no effect.
REQ-033 Address arithmetic SHALL wrap modulo 2^AW.
REQ-034 start asserted in the DONE cycle SHALL be ignored; start asserted in the cycle after done SHALL be accepted.

Reset
REQ-035 While reset=0: FSM=IDLE; i, fac and gamma =0; readAddr, writeAddr, writeOut =0; writeEn, busy, done =0.
REQ-036 Reset asserted mid-operation SHALL abort immediately with no further writes; after release the block SHALL wait for a new start.

Verification
REQ-037 Single mode, M=10, gamma=0x4000, a[0]=0x1000, a[1..10]=0x4000 -> ap[0]=0x00001000, ap[1]=0x00002000, ap[2]=0x00001000, ap[3]=0x00000800; done at T+25.
REQ-038 gamma=0x8000, a[1]=0x8000 -> L_mult saturates and round saturates: ap[1]=0x00007FFF.
REQ-039 gamma=0x4000, a[1]=0xC000 -> ap[1]=0xFFFFE000 (sign-extended).
REQ-040 Dual mode, gamma1=0x4000, gamma2=0x2000, a[1]=0x4000 -> AP[1]=0x2000, AP2[1]=0x1000; 22 writes total; done at T+49.
REQ-041 reset pulsed low at T+8, with start re-pulsed during busy in a separate run -> outputs zero immediately, no writes after reset, busy-time start ignored, and the next start gives correct results.

Source files
------------

// File: rtl/weight_az_param_if.sv
// Request, memory-read and memory-write signals of the bandwidth-expansion
// (weighted LPC) engine.
interface weight_az_param_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          start;
  logic          dual;
  logic [AW-1:0] A;
  logic [AW-1:0] AP;
  logic [AW-1:0] AP2;
  logic [AW-1:0] gammaAddr;
  logic [DW-1:0] readIn;
  logic [AW-1:0] readAddr;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] writeOut;
  logic          writeEn;
  logic          busy;
  logic          done;

  modport master (
    output start, dual, A, AP, AP2, gammaAddr, readIn,
    input  readAddr, writeAddr, writeOut, writeEn, busy, done
  );

  modport slave (
    input  start, dual, A, AP, AP2, gammaAddr, readIn,
    output readAddr, writeAddr, writeOut, writeEn, busy, done
  );
endinterface

// File: rtl/weight_az_param.sv
// Weights LPC coefficients by successive powers of gamma: ap[i] = a[i]*gamma^i
// in Q15, with one or two gamma sets read from and written back to memory.
module weight_az_param #(
  parameter int ORDER = 10,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  weight_az_param_if.slave         bus
);

  localparam int IW = $clog2(ORDER + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(ORDER);

  typedef enum logic [2:0] {IDLE, RG, LG, RA, WA, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic signed [15:0]    fac;
  logic signed [15:0]    gamma;
  logic                  dualMode;
  logic                  secondPass;
  logic [AW-1:0]         baseA;
  logic [AW-1:0]         baseAp;
  logic [AW-1:0]         baseAp2;
  logic [AW-1:0]         gammaBase;

  logic signed [15:0]    coefIn;
  logic signed [15:0]    termNext;
  logic signed [15:0]    facNext;
  logic                  unusedReadHi;

  // Q15 fractional multiply; only -1 * -1 can overflow the doubled product.
  function automatic logic signed [31:0] lMult(input logic signed [15:0] x,
                                                input logic signed [15:0] y);
    logic signed [31:0] prod;
    prod = 32'(x) * 32'(y);
    if (x == 16'sh8000 && y == 16'sh8000)
      return 32'sh7FFF_FFFF;
    return prod <<< 1;
  endfunction

  function automatic logic signed [15:0] roundSat(input logic signed [31:0] l);
    logic signed [32:0] sum;
    sum = 33'(l) + 33'sd32768;
    if (sum > 33'sh0_7FFF_FFFF)
      return 16'sh7FFF;
    return sum[31:16];
  endfunction

  function automatic logic [DW-1:0] signExt(input logic signed [15:0] v);
    return {{(DW-16){v[15]}}, v};
  endfunction

  assign coefIn       = bus.readIn[15:0];
  assign unusedReadHi = ^bus.readIn[DW-1:16];
  assign termNext     = roundSat(lMult(coefIn, fac));
  assign facNext      = roundSat(lMult(gamma, fac));

  // Operation parameters are frozen at acceptance so the inputs may change freely afterwards.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      baseA     <= bus.A;
      baseAp    <= bus.AP;
      baseAp2   <= bus.AP2;
      gammaBase <= bus.gammaAddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      fac           <= '0;
      gamma         <= '0;
      dualMode      <= 1'b0;
      secondPass    <= 1'b0;
      bus.readAddr  <= '0;
      bus.writeAddr <= '0;
      bus.writeOut  <= '0;
      bus.writeEn   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.writeEn <= 1'b0;
      bus.done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dualMode     <= bus.dual;
            secondPass   <= 1'b0;
            bus.readAddr <= bus.gammaAddr;
            bus.busy     <= 1'b1;
            state        <= RG;
          end
        end
        RG: state <= LG;
        LG: begin
          gamma        <= coefIn;
          fac          <= coefIn;
          idx          <= '0;
          bus.readAddr <= baseA;
          state        <= RA;
        end
        RA: state <= WA;
        WA: begin
          bus.writeEn   <= 1'b1;
          bus.writeAddr <= (secondPass ? baseAp2 : baseAp) + AW'(idx);
          // a[0] passes through untouched; fac only advances from i=1 onward.
          if (idx == '0) begin
            bus.writeOut <= signExt(coefIn);
          end else begin
            bus.writeOut <= signExt(termNext);
            fac          <= facNext;
          end
          idx <= idx + 1'b1;
          if (idx != LAST_IDX) begin
            bus.readAddr <= baseA + AW'(idx + 1'b1);
            state        <= RA;
          end else if (dualMode && !secondPass) begin
            secondPass   <= 1'b1;
            bus.readAddr <= gammaBase + AW'(1);
            state        <= RG;
          end else begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
